// File: rtl/pcs25g_gray6_pkg.sv
// Shared 6-state Gray pointer definitions for the 25G PCS clock-crossing FIFO.
// Holds the code constants, the encode/decode helpers and the pointer and depth sizes.
package pcs25g_gray6_pkg;

  localparam int PTR_BIN_W  = 3;
  localparam int PTR_GRAY_W = 4;
  localparam int FIFO_DEPTH = 3;

  localparam logic [PTR_GRAY_W-1:0] G0 = 4'b0000;
  localparam logic [PTR_GRAY_W-1:0] G1 = 4'b0001;
  localparam logic [PTR_GRAY_W-1:0] G2 = 4'b0011;
  localparam logic [PTR_GRAY_W-1:0] G3 = 4'b0010;
  localparam logic [PTR_GRAY_W-1:0] G4 = 4'b0110;
  localparam logic [PTR_GRAY_W-1:0] G5 = 4'b0100;

  function automatic logic [PTR_GRAY_W-1:0] gray6_enc(input logic [PTR_BIN_W-1:0] b);
    case (b)
      3'd0:    gray6_enc = G0;
      3'd1:    gray6_enc = G1;
      3'd2:    gray6_enc = G2;
      3'd3:    gray6_enc = G3;
      3'd4:    gray6_enc = G4;
      default: gray6_enc = G5;
    endcase
  endfunction

  // Illegal codes fall to 5, the same default the write-side encoder uses.
  function automatic logic [PTR_BIN_W-1:0] gray6_dec(input logic [PTR_GRAY_W-1:0] g);
    case (g)
      G0:      gray6_dec = 3'd0;
      G1:      gray6_dec = 3'd1;
      G2:      gray6_dec = 3'd2;
      G3:      gray6_dec = 3'd3;
      G4:      gray6_dec = 3'd4;
      default: gray6_dec = 3'd5;
    endcase
  endfunction

  function automatic logic gray6_legal(input logic [PTR_GRAY_W-1:0] g);
    gray6_legal = (g == G0) || (g == G1) || (g == G2) ||
                  (g == G3) || (g == G4) || (g == G5);
  endfunction

endpackage

// File: rtl/gray6_sync.sv
// Write-pointer synchroniser: the single clock-domain crossing point of the read side.
// A SYNC_STAGES-deep chain of flops, every stage cleared by reset.
module gray6_sync
  import pcs25g_gray6_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PTR_GRAY_W-1:0] gray_in,
  output logic [PTR_GRAY_W-1:0] gray_out
);

  logic [PTR_GRAY_W-1:0] sync_q [SYNC_STAGES];
  logic [PTR_GRAY_W-1:0] sync_d [SYNC_STAGES];

  always_comb begin
    sync_d[0] = gray_in;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < SYNC_STAGES; i++) begin
      if (reset) sync_q[i] <= '0;
      else       sync_q[i] <= sync_d[i];
    end
  end

  assign gray_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/gray6_rdptr_ctrl.sv
// Read-side pointer controller for the 3-entry 25G PCS clock-crossing FIFO.
// Optional pointer-integrity checking is enabled by defining GRAY6_PTR_CHK_EN.
module gray6_rdptr_ctrl
  import pcs25g_gray6_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] wr_ptr_gray,
  input  logic       rd_en,
  output logic [1:0] rd_addr,
  output logic [3:0] rd_ptr_gray,
  output logic       empty,
  output logic [1:0] level,
  output logic       rd_underflow,
  output logic       ptr_err
);

  logic [PTR_GRAY_W-1:0] wr_gray_s;
  logic [PTR_BIN_W-1:0]  wr_dec;
  logic [PTR_BIN_W-1:0]  wr_bin_s_q, wr_bin_s_d;
  logic [PTR_BIN_W-1:0]  rd_bin_q, rd_bin_d;
  logic [PTR_GRAY_W-1:0] rd_ptr_gray_q, rd_ptr_gray_d;
  logic                  rd_underflow_q, rd_underflow_d;
  logic [3:0]            diff;
  logic [PTR_BIN_W-1:0]  level_raw;
  logic                  pop;

  gray6_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset   (reset),
    .gray_in (wr_ptr_gray),
    .gray_out(wr_gray_s)
  );

  assign wr_dec = gray6_dec(wr_gray_s);

  // Both pointers are 0..5, so adding 6 before the subtraction keeps it non-negative.
  always_comb begin
    diff = {1'b0, wr_bin_s_q} + 4'd6 - {1'b0, rd_bin_q};
    if (diff >= 4'd6) diff = diff - 4'd6;
    level_raw = diff[PTR_BIN_W-1:0];
  end

  assign empty = (level_raw == '0);
  assign level = level_raw[1:0];
  assign pop   = rd_en & ~empty;

  always_comb begin
    rd_bin_d       = rd_bin_q;
    rd_underflow_d = rd_underflow_q | (rd_en & empty);
    if (pop) rd_bin_d = (rd_bin_q == 3'd5) ? 3'd0 : rd_bin_q + 3'd1;
    rd_ptr_gray_d  = gray6_enc(rd_bin_d);
  end

`ifdef GRAY6_PTR_CHK_EN
  logic       ptr_err_q, ptr_err_d;
  logic       wr_legal;
  logic [3:0] step;

  always_comb begin
    wr_legal = gray6_legal(wr_gray_s);
    step     = {1'b0, wr_dec} + 4'd6 - {1'b0, wr_bin_s_q};
    if (step >= 4'd6) step = step - 4'd6;
    wr_bin_s_d = wr_legal ? wr_dec : wr_bin_s_q;
    ptr_err_d  = ptr_err_q | ~wr_legal | (wr_legal & (step > 4'd1)) |
                 (level_raw > 3'd3);
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_err_q <= 1'b0;
    else       ptr_err_q <= ptr_err_d;
  end

  assign ptr_err = ptr_err_q;
`else
  assign wr_bin_s_d = wr_dec;
  assign ptr_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bin_s_q     <= '0;
      rd_bin_q       <= '0;
      rd_ptr_gray_q  <= G0;
      rd_underflow_q <= 1'b0;
    end else begin
      wr_bin_s_q     <= wr_bin_s_d;
      rd_bin_q       <= rd_bin_d;
      rd_ptr_gray_q  <= rd_ptr_gray_d;
      rd_underflow_q <= rd_underflow_d;
    end
  end

  assign rd_addr      = (rd_bin_q >= 3'(FIFO_DEPTH)) ? 2'(rd_bin_q - 3'(FIFO_DEPTH))
                                                     : rd_bin_q[1:0];
  assign rd_ptr_gray  = rd_ptr_gray_q;
  assign rd_underflow = rd_underflow_q;

endmodule

// File: tb/tb_gray6_rdptr_ctrl.sv
// Directed bench for gray6_rdptr_ctrl with SYNC_STAGES=2 (write-pointer latency 3 edges).
// Expectations for the illegal-code and jump steps follow GRAY6_PTR_CHK_EN.
module tb_gray6_rdptr_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] wr_ptr_gray;
  logic       rd_en;
  logic [1:0] rd_addr;
  logic [3:0] rd_ptr_gray;
  logic       empty;
  logic [1:0] level;
  logic       rd_underflow;
  logic       ptr_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gray6_rdptr_ctrl #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_ptr_gray (wr_ptr_gray),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_ptr_gray (rd_ptr_gray),
    .empty       (empty),
    .level       (level),
    .rd_underflow(rd_underflow),
    .ptr_err     (ptr_err)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; wr_ptr_gray = 4'b0000; rd_en = 1'b0;
    tick(2);
    check("rst_empty", {7'd0, empty}, 8'd1);
    check("rst_level", {6'd0, level}, 8'd0);
    check("rst_rdptr", {4'd0, rd_ptr_gray}, 8'h0);
    check("rst_addr", {6'd0, rd_addr}, 8'd0);
    check("rst_unf", {7'd0, rd_underflow}, 8'd0);
    check("rst_err", {7'd0, ptr_err}, 8'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_empty", {7'd0, empty}, 8'd1);
      check("idle_level", {6'd0, level}, 8'd0);
    end

    // Fill to 3: one write step every 4 cycles
    wr_ptr_gray = 4'b0001; tick(2);
    check("lat_not_yet", {6'd0, level}, 8'd0);
    tick();
    check("lat_level1", {6'd0, level}, 8'd1);
    check("lat_nonempty", {7'd0, empty}, 8'd0);
    tick();
    wr_ptr_gray = 4'b0011; tick(4);
    check("fill_level2", {6'd0, level}, 8'd2);
    wr_ptr_gray = 4'b0010; tick(4);
    check("fill_level3", {6'd0, level}, 8'd3);
    check("fill_empty", {7'd0, empty}, 8'd0);

    // Three pops drain it
    rd_en = 1'b1;
    check("pop1_addr", {6'd0, rd_addr}, 8'd0);
    tick();
    check("pop1_gray", {4'd0, rd_ptr_gray}, 8'h1);
    check("pop1_level", {6'd0, level}, 8'd2);
    check("pop2_addr", {6'd0, rd_addr}, 8'd1);
    tick();
    check("pop2_gray", {4'd0, rd_ptr_gray}, 8'h3);
    check("pop2_level", {6'd0, level}, 8'd1);
    check("pop3_addr", {6'd0, rd_addr}, 8'd2);
    tick();
    rd_en = 1'b0;
    check("pop3_gray", {4'd0, rd_ptr_gray}, 8'h2);
    check("pop3_level", {6'd0, level}, 8'd0);
    check("pop3_empty", {7'd0, empty}, 8'd1);

    // Write through 4,5,0 then pop across the 5->0 wrap
    wr_ptr_gray = 4'b0110; tick(4);
    wr_ptr_gray = 4'b0100; tick(4);
    wr_ptr_gray = 4'b0000; tick(4);
    check("wrap_level3", {6'd0, level}, 8'd3);
    rd_en = 1'b1;
    check("wpop1_addr", {6'd0, rd_addr}, 8'd0);
    tick();
    check("wpop1_gray", {4'd0, rd_ptr_gray}, 8'h6);
    check("wpop2_addr", {6'd0, rd_addr}, 8'd1);
    tick();
    check("wpop2_gray", {4'd0, rd_ptr_gray}, 8'h4);
    check("wpop3_addr", {6'd0, rd_addr}, 8'd2);
    tick();
    rd_en = 1'b0;
    check("wpop3_gray", {4'd0, rd_ptr_gray}, 8'h0);
    check("wrap_addr0", {6'd0, rd_addr}, 8'd0);
    check("wrap_empty", {7'd0, empty}, 8'd1);

    wr_ptr_gray = 4'b0001; tick(4);
    check("sim_pre_level", {6'd0, level}, 8'd1);
    // Pop lands on the same edge that the write advance reaches wr_bin_s
    wr_ptr_gray = 4'b0011; tick(2);
    rd_en = 1'b1;
    check("sim_before", {6'd0, level}, 8'd1);
    tick();
    rd_en = 1'b0;
    check("sim_after_level", {6'd0, level}, 8'd1);
    check("sim_after_gray", {4'd0, rd_ptr_gray}, 8'h1);

    wr_ptr_gray = 4'b0010; tick(4);
    check("w5_level2", {6'd0, level}, 8'd2);
    rd_en = 1'b1;
    tick();
    check("wpop5_gray", {4'd0, rd_ptr_gray}, 8'h3);
    tick();
    rd_en = 1'b0;
    check("wpop6_gray", {4'd0, rd_ptr_gray}, 8'h2);
    check("wpop6_empty", {7'd0, empty}, 8'd1);
    check("wrap_no_err", {7'd0, ptr_err}, 8'd0);
    check("wrap_no_unf", {7'd0, rd_underflow}, 8'd0);

    // Pop while empty
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("unf_gray", {4'd0, rd_ptr_gray}, 8'h2);
    check("unf_set", {7'd0, rd_underflow}, 8'd1);
    check("unf_level", {6'd0, level}, 8'd0);
    tick(5);
    check("unf_sticky", {7'd0, rd_underflow}, 8'd1);

    // Illegal code 1111 with wr_bin_s=3, rd_bin=3
    wr_ptr_gray = 4'b1111; tick(2);
    check("ill_err_early", {7'd0, ptr_err}, 8'd0);
    tick();
`ifdef GRAY6_PTR_CHK_EN
    check("ill_err", {7'd0, ptr_err}, 8'd1);
    check("ill_level", {6'd0, level}, 8'd0);
    tick(2);
    check("ill_err_sticky", {7'd0, ptr_err}, 8'd1);
`else
    check("ill_err", {7'd0, ptr_err}, 8'd0);
    check("ill_level", {6'd0, level}, 8'd2);
    check("ill_empty", {7'd0, empty}, 8'd0);
`endif

    // Reset mid-operation discards everything
    reset = 1'b1; wr_ptr_gray = 4'b0000;
    tick();
    reset = 1'b0;
    check("mrst_unf", {7'd0, rd_underflow}, 8'd0);
    check("mrst_err", {7'd0, ptr_err}, 8'd0);
    check("mrst_gray", {4'd0, rd_ptr_gray}, 8'h0);
    check("mrst_addr", {6'd0, rd_addr}, 8'd0);
    check("mrst_empty", {7'd0, empty}, 8'd1);
    tick(4);
    check("mrst_level", {6'd0, level}, 8'd0);

    // Two-step jump 0 -> 2
    wr_ptr_gray = 4'b0011; tick(3);
    check("jump_level", {6'd0, level}, 8'd2);
`ifdef GRAY6_PTR_CHK_EN
    check("jump_err", {7'd0, ptr_err}, 8'd1);
`else
    check("jump_err", {7'd0, ptr_err}, 8'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
